alu_ctrl: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/alu_ctrl_regfile.sv | 31 +++
 rtl/alu_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl shared definitions: opcodes, FSM states, ALU select codes.
// Imported by the controller top and its register file.
package alu_ctrl_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_EXEC = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [4:0] SEL_ADD = 5'b00000;
  localparam logic [4:0] SEL_INC = 5'b00001;
  localparam logic [4:0] SEL_DEC = 5'b00010;
  localparam logic [4:0] SEL_LSH = 5'b00011;
  localparam logic [4:0] SEL_AND = 5'b10000;
  localparam logic [4:0] SEL_OR  = 5'b10100;
  localparam logic [4:0] SEL_XOR = 5'b11000;
  localparam logic [4:0] SEL_NOT = 5'b11100;

endpackage

// File: rtl/alu_ctrl_regfile.sv
// NREG x 4-bit register file: one sync write port,
// two combinational read ports, sync reset to zero.
module alu_ctrl_regfile #(
  parameter int NREG = 4,
  parameter int IW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [IW-1:0] raddr_a,
  input  logic [IW-1:0] raddr_b,
  output logic [3:0]    rdata_a,
  output logic [3:0]    rdata_b
);

  logic [NREG-1:0][3:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_ctrl.sv
// Operand/issue controller for the 4-bit ALU: one command in flight,
// EXEC writes the ALU result back with carry/zero flags.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NREG = 4,
  parameter int IW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [4:0]    cmd_sel,
  input  logic          cmd_cin,
  input  logic [IW-1:0] cmd_ra,
  input  logic [IW-1:0] cmd_rb,
  input  logic [IW-1:0] cmd_rd,
  input  logic [3:0]    cmd_imm,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [4:0]    alu_s,
  output logic          alu_cin,
  input  logic [4:0]    alu_c,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [4:0]    rsp_data,
  output logic          rsp_err,
  output logic          flag_c,
  output logic          flag_z
);

  state_t        state;
  state_t        state_d;
  logic [IW-1:0] rd_q;
  logic [3:0]    ra_data;
  logic [3:0]    rb_data;
  logic          accept;
  logic          in_exec;
  logic          we;
  logic [IW-1:0] waddr;
  logic [3:0]    wdata;

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == ST_RESP);
  assign in_exec   = (state == ST_EXEC);

  // LOAD writes at accept, EXEC writes at end of its cycle
  assign we    = (accept && cmd_op == OP_LOAD) || in_exec;
  assign waddr = in_exec ? rd_q : cmd_rd;
  assign wdata = in_exec ? alu_c[3:0] : cmd_imm;

  alu_ctrl_regfile #(
    .NREG (NREG),
    .IW   (IW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (cmd_ra),
    .raddr_b (cmd_rb),
    .rdata_a (ra_data),
    .rdata_b (rb_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (accept) begin
          state_d = (cmd_op == OP_EXEC) ? ST_EXEC : ST_RESP;
        end
      end
      (state == ST_EXEC): state_d = ST_RESP;
      (state == ST_RESP): begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= '0;
      alu_cin  <= 1'b0;
      rd_q     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      if (accept) begin
        unique case (cmd_op)
          OP_LOAD: rsp_data <= {1'b0, cmd_imm};
          OP_READ: rsp_data <= {1'b0, ra_data};
          OP_EXEC: begin
            alu_a   <= ra_data;
            alu_b   <= rb_data;
            alu_s   <= cmd_sel;
            alu_cin <= cmd_cin;
            rd_q    <= cmd_rd;
          end
          default: begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end
        endcase
      end
      if (in_exec) begin
        rsp_data <= alu_c;
        flag_c   <= alu_c[4];
        flag_z   <= (alu_c[3:0] == 4'd0);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized self-checking bench for alu_ctrl with a behavioural ALU
// and a register/flag reference model.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_sel;
  logic       cmd_cin;
  logic [1:0] cmd_ra;
  logic [1:0] cmd_rb;
  logic [1:0] cmd_rd;
  logic [3:0] cmd_imm;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_s;
  logic       alu_cin;
  logic [4:0] alu_c;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_data;
  logic       rsp_err;
  logic       flag_c;
  logic       flag_z;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] m_reg [4];
  logic       m_c;
  logic       m_z;
  logic [4:0] sels [8] = '{SEL_ADD, SEL_INC, SEL_DEC, SEL_LSH,
                           SEL_AND, SEL_OR, SEL_XOR, SEL_NOT};

  always #5 clk = ~clk;

  alu_ctrl #(.NREG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_sel   (cmd_sel),
    .cmd_cin   (cmd_cin),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_rd    (cmd_rd),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_cin   (alu_cin),
    .alu_c     (alu_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .flag_c    (flag_c),
    .flag_z    (flag_z)
  );

  function automatic logic [4:0] alu_f(logic [3:0] a, logic [3:0] b,
                                       logic [4:0] s, logic ci);
    case (s)
      SEL_ADD: return {1'b0, a} + {1'b0, b} + {4'd0, ci};
      SEL_INC: return {1'b0, a} + 5'd1;
      SEL_DEC: return {1'b0, a} - 5'd1;
      SEL_LSH: return {a, ci};
      SEL_AND: return {1'b0, a & b};
      SEL_OR:  return {1'b0, a | b};
      SEL_XOR: return {1'b0, a ^ b};
      SEL_NOT: return ~{1'b0, a};
      default: return 5'd0;
    endcase
  endfunction

  always_comb alu_c = alu_f(alu_a, alu_b, alu_s, alu_cin);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] sel,
                        input logic ci, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [1:0] rd,
                        input logic [3:0] imm, input int hold);
    logic [4:0] exp;
    logic       experr;
    logic [4:0] r;
    int         n;
    experr = 1'b0;
    exp = 5'd0;
    case (op)
      OP_LOAD: begin
        exp = {1'b0, imm};
        m_reg[rd] = imm;
      end
      OP_READ: exp = {1'b0, m_reg[ra]};
      OP_EXEC: begin
        r = alu_f(m_reg[ra], m_reg[rb], sel, ci);
        exp = r;
        m_reg[rd] = r[3:0];
        m_c = r[4];
        m_z = (r[3:0] == 4'd0);
      end
      default: experr = 1'b1;
    endcase
    @(negedge clk);
    cmd_op = op; cmd_sel = sel; cmd_cin = ci;
    cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk("latency", 32'(n), (op == OP_EXEC) ? 32'd2 : 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(exp));
    chk("rsp_err", 32'(rsp_err), 32'(experr));
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 2'($urandom);
      cmd_rd = 2'($urandom);
      cmd_imm = 4'($urandom);
      @(negedge clk);
      chk("hold_ready", 32'(cmd_ready), 32'd0);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(exp));
      chk("hold_err", 32'(rsp_err), 32'(experr));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("ready_after", 32'(cmd_ready), 32'd1);
    chk("valid_after", 32'(rsp_valid), 32'd0);
    chk("err_after", 32'(rsp_err), 32'd0);
    chk("flag_c", 32'(flag_c), 32'(m_c));
    chk("flag_z", 32'(flag_z), 32'(m_z));
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_sel = '0; cmd_cin = 1'b0;
    cmd_ra = '0; cmd_rb = '0; cmd_rd = '0; cmd_imm = '0;
    rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_flags", 32'({flag_c, flag_z}), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_s, alu_cin}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_out_of_rst", 32'(cmd_ready), 32'd1);

    do_cmd(OP_LOAD, '0, 0, 0, 0, 1, 4'd3, 0);
    do_cmd(OP_LOAD, '0, 0, 0, 0, 2, 4'd5, 0);
    do_cmd(OP_EXEC, SEL_ADD, 0, 1, 2, 3, 4'd0, 0);
    do_cmd(OP_READ, '0, 0, 3, 0, 0, 4'd0, 0);
    do_cmd(OP_LOAD, '0, 0, 0, 0, 1, 4'hF, 0);
    do_cmd(OP_LOAD, '0, 0, 0, 0, 2, 4'h1, 0);
    do_cmd(OP_EXEC, SEL_ADD, 0, 1, 2, 0, 4'd0, 0);
    do_cmd(OP_READ, '0, 0, 0, 0, 0, 4'd0, 0);
    do_cmd(OP_LOAD, '0, 0, 0, 0, 1, 4'hC, 0);
    do_cmd(OP_LOAD, '0, 0, 0, 0, 2, 4'hA, 0);
    do_cmd(OP_EXEC, SEL_AND, 0, 1, 2, 3, 4'd0, 0);
    do_cmd(OP_LOAD, '0, 0, 0, 0, 1, 4'h5, 0);
    do_cmd(OP_EXEC, SEL_NOT, 0, 1, 0, 3, 4'd0, 5);
    do_cmd(OP_RSVD, '0, 0, 0, 0, 2, 4'h9, 0);
    do_cmd(OP_READ, '0, 0, 2, 0, 0, 4'd0, 0);
    do_cmd(OP_LOAD, '0, 0, 0, 0, 0, 4'h6, 0);

    for (int k = 0; k < 200; k++) begin
      do_cmd(2'($urandom), sels[$urandom_range(0, 7)], 1'($urandom),
             2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom),
             $urandom_range(0, 3));
    end

    // reset landing while an EXEC is mid-flight
    do_cmd(OP_LOAD, '0, 0, 0, 0, 1, 4'hF, 0);
    do_cmd(OP_LOAD, '0, 0, 0, 0, 2, 4'h1, 0);
    do_cmd(OP_LOAD, '0, 0, 0, 0, 3, 4'h7, 0);
    do_cmd(OP_EXEC, SEL_ADD, 0, 1, 2, 0, 4'd0, 0);
    @(negedge clk);
    cmd_op = OP_EXEC; cmd_sel = SEL_ADD; cmd_cin = 1'b0;
    cmd_ra = 2'd1; cmd_rb = 2'd2; cmd_rd = 2'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("exec_rst_valid", 32'(rsp_valid), 32'd0);
    chk("exec_rst_ready", 32'(cmd_ready), 32'd0);
    chk("exec_rst_flags", 32'({flag_c, flag_z}), 32'd0);
    chk("exec_rst_alu", 32'({alu_a, alu_b, alu_s, alu_cin}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("exec_rst_ready2", 32'(cmd_ready), 32'd1);
    chk("exec_rst_valid2", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_cmd(OP_READ, '0, 0, 2'(i), 0, 0, 4'd0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
